// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode/issue hazard, forwarding and long-latency scoreboard.
// Resolves both source operands from NUM_FWD ordered bypass slots, the
// long-latency writeback port or the register file, and raises one issue
// stall for RAW, WAW and capacity hazards.
// Build option: define ORION_FWD_EN to enable operand bypassing. Without it,
// operands always come from the register file and any in-flight producer of
// a used source stalls issue.

module issue_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_FWD  = 2,
    parameter int MAX_LONG = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    id_valid_i,
    input  logic [4:0]              rs1_s_i,
    input  logic [4:0]              rs2_s_i,
    input  logic                    rs1_used_i,
    input  logic                    rs2_used_i,
    input  logic [4:0]              rd_s_i,
    input  logic                    rd_we_i,
    input  logic                    long_lat_i,
    input  logic [XLEN-1:0]         rs1_rf_i,
    input  logic [XLEN-1:0]         rs2_rf_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_s_i,
    input  logic [NUM_FWD-1:0]      fwd_rdy_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_rd_v_i,
    input  logic                    lwb_valid_i,
    input  logic [4:0]              lwb_rd_s_i,
    input  logic [XLEN-1:0]         lwb_rd_v_i,
    output logic                    issue_stall_o,
    output logic                    issue_fire_o,
    output logic [XLEN-1:0]         rs1_v_o,
    output logic [XLEN-1:0]         rs2_v_o,
    output logic [$clog2(MAX_LONG+1)-1:0] inflight_o
);

    localparam int CW = $clog2(MAX_LONG + 1);

    // Result of searching the bypass slots for one source index.
    typedef struct packed {
        logic            hit;
        logic            rdy;
        logic [XLEN-1:0] val;
    } fwd_res_t;

    // Youngest matching slot wins: scan from oldest to youngest so the
    // lowest index is written last.
    function automatic fwd_res_t fwd_lookup(
        input logic [4:0]              rs,
        input logic [NUM_FWD-1:0]      valid,
        input logic [5*NUM_FWD-1:0]    rd_s,
        input logic [NUM_FWD-1:0]      rdy,
        input logic [XLEN*NUM_FWD-1:0] rd_v
    );
        fwd_res_t res;
        res.hit = 1'b0;
        res.rdy = 1'b0;
        res.val = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (valid[i] && (rd_s[5*i +: 5] == rs)) begin
                res.hit = 1'b1;
                res.rdy = rdy[i];
                res.val = rd_v[XLEN*i +: XLEN];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [31:1]   pending_r;
    logic [31:1]   pending_nxt_s;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] inflight_nxt_s;

    logic [31:0]   pending_full_s;
    fwd_res_t      rs1_fwd_s;
    fwd_res_t      rs2_fwd_s;
    logic          rs1_nz_s;
    logic          rs2_nz_s;
    logic          rd_nz_s;
    logic          rs1_lwb_s;
    logic          rs2_lwb_s;
    logic          rs1_pend_s;
    logic          rs2_pend_s;
    logic          rs1_haz_s;
    logic          rs2_haz_s;
    logic          waw_s;
    logic          cap_s;
    logic          stall_s;
    logic          fire_s;
    logic          set_en_s;
    logic          clr_en_s;
    logic          dec_en_s;

    assign pending_full_s = {pending_r, 1'b0};
    assign rs1_nz_s       = (rs1_s_i != 5'd0);
    assign rs2_nz_s       = (rs2_s_i != 5'd0);
    assign rd_nz_s        = (rd_s_i != 5'd0);

    // Per-operand match against bypass slots, writeback port and scoreboard.
    always_comb begin
        rs1_fwd_s  = fwd_lookup(rs1_s_i, fwd_valid_i, fwd_rd_s_i, fwd_rdy_i, fwd_rd_v_i);
        rs2_fwd_s  = fwd_lookup(rs2_s_i, fwd_valid_i, fwd_rd_s_i, fwd_rdy_i, fwd_rd_v_i);
        rs1_lwb_s  = lwb_valid_i && (lwb_rd_s_i == rs1_s_i) && rs1_nz_s;
        rs2_lwb_s  = lwb_valid_i && (lwb_rd_s_i == rs2_s_i) && rs2_nz_s;
        rs1_pend_s = pending_full_s[rs1_s_i];
        rs2_pend_s = pending_full_s[rs2_s_i];
    end

`ifdef ORION_FWD_EN
    // Operand mux: youngest bypass slot, then long writeback, then regfile.
    always_comb begin
        rs1_v_o = rs1_rf_i;
        rs2_v_o = rs2_rf_i;
        if (rs1_nz_s && rs1_fwd_s.hit) begin
            rs1_v_o = rs1_fwd_s.val;
        end else if (rs1_lwb_s) begin
            rs1_v_o = lwb_rd_v_i;
        end else begin
            rs1_v_o = rs1_rf_i;
        end
        if (rs2_nz_s && rs2_fwd_s.hit) begin
            rs2_v_o = rs2_fwd_s.val;
        end else if (rs2_lwb_s) begin
            rs2_v_o = lwb_rd_v_i;
        end else begin
            rs2_v_o = rs2_rf_i;
        end
    end

    // RAW hazards: winning slot not ready yet, or still pending without lwb.
    always_comb begin
        rs1_haz_s = rs1_used_i && rs1_nz_s &&
                    ((rs1_fwd_s.hit && !rs1_fwd_s.rdy) || (rs1_pend_s && !rs1_lwb_s));
        rs2_haz_s = rs2_used_i && rs2_nz_s &&
                    ((rs2_fwd_s.hit && !rs2_fwd_s.rdy) || (rs2_pend_s && !rs2_lwb_s));
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{rs1_fwd_s.val, rs1_fwd_s.rdy, rs2_fwd_s.val, rs2_fwd_s.rdy, lwb_rd_v_i};

    // Without bypassing the register file is the only operand source.
    always_comb begin
        rs1_v_o = rs1_rf_i;
        rs2_v_o = rs2_rf_i;
    end

    // RAW hazards: any producer still in flight holds issue until it retires.
    always_comb begin
        rs1_haz_s = rs1_used_i && rs1_nz_s && (rs1_fwd_s.hit || rs1_lwb_s || rs1_pend_s);
        rs2_haz_s = rs2_used_i && rs2_nz_s && (rs2_fwd_s.hit || rs2_lwb_s || rs2_pend_s);
    end
`endif

    // Combine hazards into the single stall and derive the fire strobe.
    always_comb begin
        waw_s   = rd_we_i && rd_nz_s && pending_full_s[rd_s_i];
        cap_s   = long_lat_i && rd_we_i && (inflight_r == CW'(MAX_LONG)) && !lwb_valid_i;
        stall_s = id_valid_i && (rs1_haz_s || rs2_haz_s || waw_s || cap_s);
        fire_s  = id_valid_i && !flush_i && !stall_s;
    end

    assign issue_stall_o = stall_s;
    assign issue_fire_o  = fire_s;
    assign inflight_o    = inflight_r;

    // Scoreboard next state: set on long-op issue, clear on long writeback.
    always_comb begin
        pending_nxt_s  = pending_r;
        inflight_nxt_s = inflight_r;
        set_en_s       = fire_s && long_lat_i && rd_we_i && rd_nz_s;
        clr_en_s       = lwb_valid_i && (lwb_rd_s_i != 5'd0);
        dec_en_s       = clr_en_s && (inflight_r != '0);
        if (clr_en_s) begin
            pending_nxt_s[lwb_rd_s_i] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (set_en_s) begin
            pending_nxt_s[rd_s_i] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        case ({set_en_s, dec_en_s})
            2'b10:   inflight_nxt_s = inflight_r + CW'(1);
            2'b01:   inflight_nxt_s = inflight_r - CW'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Scoreboard state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r  <= '0;
            inflight_r <= '0;
        end else begin
            pending_r  <= pending_nxt_s;
            inflight_r <= inflight_nxt_s;
        end
    end

    issue_scoreboard_chk #(
        .MAX_LONG (MAX_LONG),
        .CW       (CW)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lwb_valid_i (lwb_valid_i),
        .lwb_rd_s_i  (lwb_rd_s_i),
        .inflight    (inflight_r)
    );

endmodule

// Protocol checks for the long-latency writeback interface.
module issue_scoreboard_chk #(
    parameter int MAX_LONG = 4,
    parameter int CW       = 3
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          lwb_valid_i,
    input logic [4:0]    lwb_rd_s_i,
    input logic [CW-1:0] inflight
);

    // A writeback must always have an outstanding long op to retire.
    lwb_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        (lwb_valid_i && (lwb_rd_s_i != 5'd0)) |-> (inflight != '0));

    // The outstanding count never exceeds the configured capacity.
    inflight_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (inflight <= CW'(MAX_LONG)));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (NUM_FWD=2, MAX_LONG=2); expectations
// follow the ORION_FWD_EN setting of the build.
module tb_issue_scoreboard;

    localparam int XLEN = 32;
    localparam int NF   = 2;
    localparam int ML   = 2;
    localparam int CW   = $clog2(ML + 1);
`ifdef ORION_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [31:0] RF1 = 32'h1111_0001;
    localparam logic [31:0] RF2 = 32'h2222_0002;

    logic              clk = 1'b0;
    logic              rst, flush, id_valid;
    logic [4:0]        rs1_s, rs2_s, rd_s, lwb_rd_s;
    logic              rs1_used, rs2_used, rd_we, long_lat, lwb_valid;
    logic [XLEN-1:0]   rs1_rf, rs2_rf, lwb_rd_v;
    logic [NF-1:0]     fwd_valid, fwd_rdy;
    logic [5*NF-1:0]   fwd_rd_s;
    logic [XLEN*NF-1:0] fwd_rd_v;
    logic              issue_stall, issue_fire;
    logic [XLEN-1:0]   rs1_v, rs2_v;
    logic [CW-1:0]     inflight;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.XLEN(XLEN), .NUM_FWD(NF), .MAX_LONG(ML)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_valid_i(id_valid),
        .rs1_s_i(rs1_s), .rs2_s_i(rs2_s), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .rd_s_i(rd_s), .rd_we_i(rd_we), .long_lat_i(long_lat),
        .rs1_rf_i(rs1_rf), .rs2_rf_i(rs2_rf),
        .fwd_valid_i(fwd_valid), .fwd_rd_s_i(fwd_rd_s), .fwd_rdy_i(fwd_rdy), .fwd_rd_v_i(fwd_rd_v),
        .lwb_valid_i(lwb_valid), .lwb_rd_s_i(lwb_rd_s), .lwb_rd_v_i(lwb_rd_v),
        .issue_stall_o(issue_stall), .issue_fire_o(issue_fire),
        .rs1_v_o(rs1_v), .rs2_v_o(rs2_v), .inflight_o(inflight)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
        rs1_s = 5'd0; rs2_s = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd_s = 5'd0; rd_we = 1'b0; long_lat = 1'b0;
        rs1_rf = RF1; rs2_rf = RF2;
        fwd_valid = '0; fwd_rdy = '0; fwd_rd_s = '0; fwd_rd_v = '0;
        lwb_valid = 1'b0; lwb_rd_s = 5'd0; lwb_rd_v = 32'h0;
    endtask

    task automatic set_fwd(input int i, input logic v, input logic [4:0] rd,
                           input logic rdy, input logic [31:0] val);
        fwd_valid[i]          = v;
        fwd_rd_s[5*i +: 5]    = rd;
        fwd_rdy[i]            = rdy;
        fwd_rd_v[XLEN*i +: XLEN] = val;
    endtask

    task automatic long_op(input logic [4:0] rd);
        id_valid = 1'b1; rd_s = rd; rd_we = 1'b1; long_lat = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        // reset state
        idle(); id_valid = 1'b1; #1;
        check_val("rst_stall", 32'(issue_stall), 32'd0);
        check_val("rst_fire", 32'(issue_fire), 32'd1);
        check_val("rst_inflight", 32'(inflight), 32'd0);
        check_val("rst_rs1", rs1_v, RF1);

        // two slots match: slot 0 wins
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd5; rs1_used = 1'b1;
        set_fwd(0, 1'b1, 5'd5, 1'b1, 32'h11); set_fwd(1, 1'b1, 5'd5, 1'b1, 32'h22); #1;
        check_val("fwd_prio_val", rs1_v, FWD ? 32'h11 : RF1);
        check_val("fwd_prio_stall", 32'(issue_stall), FWD ? 32'd0 : 32'd1);
        check_val("fwd_prio_fire", 32'(issue_fire), FWD ? 32'd1 : 32'd0);

        // only slot 1 matches
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd5; rs1_used = 1'b1;
        set_fwd(0, 1'b1, 5'd8, 1'b1, 32'h33); set_fwd(1, 1'b1, 5'd5, 1'b1, 32'h22); #1;
        check_val("fwd_slot1_val", rs1_v, FWD ? 32'h22 : RF1);

        // load-use: slot 0 not ready stalls
        @(negedge clk); idle(); id_valid = 1'b1; rs2_s = 5'd7; rs2_used = 1'b1;
        set_fwd(0, 1'b1, 5'd7, 1'b0, 32'h0); #1;
        check_val("ld_use_stall", 32'(issue_stall), 32'd1);
        check_val("ld_use_fire", 32'(issue_fire), 32'd0);
        @(negedge clk);
        set_fwd(0, 1'b0, 5'd0, 1'b0, 32'h0); set_fwd(1, 1'b1, 5'd7, 1'b1, 32'hAB); #1;
        check_val("ld_use_val", rs2_v, FWD ? 32'hAB : RF2);
        check_val("ld_use_fire2", 32'(issue_fire), FWD ? 32'd1 : 32'd0);

        // unused source never stalls
        @(negedge clk); idle(); id_valid = 1'b1; rs2_s = 5'd7;
        set_fwd(0, 1'b1, 5'd7, 1'b0, 32'h0); #1;
        check_val("unused_src_stall", 32'(issue_stall), 32'd0);
        // no valid instruction, no stall
        @(negedge clk); idle(); rs2_s = 5'd7; rs2_used = 1'b1;
        set_fwd(0, 1'b1, 5'd7, 1'b0, 32'h0); #1;
        check_val("novalid_stall", 32'(issue_stall), 32'd0);
        check_val("novalid_fire", 32'(issue_fire), 32'd0);

        // long op rd=3 then consumer waits for lwb
        @(negedge clk); idle(); long_op(5'd3); #1;
        check_val("long3_fire", 32'(issue_fire), 32'd1);
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd3; rs1_used = 1'b1; #1;
        check_val("long3_inflight", 32'(inflight), 32'd1);
        check_val("long3_raw_stall", 32'(issue_stall), 32'd1);
        @(negedge clk); lwb_valid = 1'b1; lwb_rd_s = 5'd3; lwb_rd_v = 32'hDEAD; #1;
        check_val("lwb_byp_stall", 32'(issue_stall), FWD ? 32'd0 : 32'd1);
        check_val("lwb_byp_val", rs1_v, FWD ? 32'hDEAD : RF1);
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd3; rs1_used = 1'b1; #1;
        check_val("long3_cleared", 32'(issue_stall), 32'd0);
        check_val("long3_inflight0", 32'(inflight), 32'd0);
        check_val("long3_rf", rs1_v, RF1);

        // capacity with MAX_LONG=2
        @(negedge clk); idle(); long_op(5'd4); #1;
        check_val("cap_fire4", 32'(issue_fire), 32'd1);
        @(negedge clk); idle(); long_op(5'd6); #1;
        check_val("cap_fire6", 32'(issue_fire), 32'd1);
        @(negedge clk); idle(); long_op(5'd9); #1;
        check_val("cap_inflight2", 32'(inflight), 32'd2);
        check_val("cap_stall", 32'(issue_stall), 32'd1);
        @(negedge clk); lwb_valid = 1'b1; lwb_rd_s = 5'd4; lwb_rd_v = 32'h44; #1;
        check_val("cap_lwb_fire", 32'(issue_fire), 32'd1);
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd4; rs1_used = 1'b1; #1;
        check_val("cap_inflight_kept", 32'(inflight), 32'd2);
        check_val("cap_rd4_free", 32'(issue_stall), 32'd0);
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd6; rs1_used = 1'b1; #1;
        check_val("cap_rd6_pend", 32'(issue_stall), 32'd1);

        // WAW on pending rd=9, even with its lwb this cycle
        @(negedge clk); idle(); id_valid = 1'b1; rd_s = 5'd9; rd_we = 1'b1; #1;
        check_val("waw_stall", 32'(issue_stall), 32'd1);
        @(negedge clk); lwb_valid = 1'b1; lwb_rd_s = 5'd9; lwb_rd_v = 32'h99; #1;
        check_val("waw_lwb_stall", 32'(issue_stall), 32'd1);
        @(negedge clk); idle(); id_valid = 1'b1; rd_s = 5'd9; rd_we = 1'b1; #1;
        check_val("waw_clear", 32'(issue_stall), 32'd0);
        check_val("waw_inflight1", 32'(inflight), 32'd1);
        @(negedge clk); idle(); lwb_valid = 1'b1; lwb_rd_s = 5'd6;
        @(negedge clk); idle(); #1;
        check_val("drain_inflight0", 32'(inflight), 32'd0);

        // flush suppresses fire and scoreboard set
        @(negedge clk); idle(); long_op(5'd10); flush = 1'b1; #1;
        check_val("flush_fire", 32'(issue_fire), 32'd0);
        check_val("flush_stall", 32'(issue_stall), 32'd0);
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd10; rs1_used = 1'b1; #1;
        check_val("flush_inflight", 32'(inflight), 32'd0);
        check_val("flush_no_pend", 32'(issue_stall), 32'd0);

        // x0 sources and destination
        @(negedge clk); idle(); long_op(5'd0); rs1_used = 1'b1; rs2_used = 1'b1;
        rs1_rf = 32'h0; rs2_rf = 32'h0;
        set_fwd(0, 1'b1, 5'd0, 1'b0, 32'h55); lwb_valid = 1'b1; lwb_rd_s = 5'd0; lwb_rd_v = 32'h66; #1;
        check_val("x0_stall", 32'(issue_stall), 32'd0);
        check_val("x0_rs1", rs1_v, 32'h0);
        check_val("x0_rs2", rs2_v, 32'h0);
        check_val("x0_fire", 32'(issue_fire), 32'd1);
        @(negedge clk); idle(); #1;
        check_val("x0_inflight", 32'(inflight), 32'd0);

        // reset mid-operation drops pending state
        @(negedge clk); idle(); long_op(5'd11); #1;
        check_val("mid_fire", 32'(issue_fire), 32'd1);
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); idle(); id_valid = 1'b1; rs1_s = 5'd11; rs1_used = 1'b1; #1;
        check_val("mid_rst_inflight", 32'(inflight), 32'd0);
        check_val("mid_rst_stall", 32'(issue_stall), 32'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
